// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: load alignment and extension at capture, a two-entry
// skid buffer between MEM and write-back, and a forwarding tap off the head.
module mem_wb_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned OFF_W      = $clog2(DATA_W / 8)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     read_data_in,
    input  logic [REG_ADDR_W-1:0] write_reg_in,
    input  logic                  mem_to_reg_in,
    input  logic                  reg_write_in,
    input  logic [1:0]            load_size_in,
    input  logic                  load_signed_in,
    input  logic [OFF_W-1:0]      byte_off_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     wb_data_out,
    output logic [REG_ADDR_W-1:0] write_reg_out,
    output logic                  reg_write_out,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0]     fwd_data
);

    localparam logic [DATA_W-1:0] MASK_B     = DATA_W'(64'h0000_0000_0000_00FF);
    localparam logic [DATA_W-1:0] MASK_H     = DATA_W'(64'h0000_0000_0000_FFFF);
    localparam logic [DATA_W-1:0] MASK_W     = DATA_W'(64'h0000_0000_FFFF_FFFF);
    localparam logic [OFF_W-1:0]  HALF_ALIGN = ~OFF_W'(1);
    localparam logic [OFF_W-1:0]  WORD_ALIGN = ~OFF_W'(3);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [OFF_W-1:0]        eff_off;
    logic [DATA_W-1:0]       shifted;
    logic [DATA_W-1:0]       keep_mask;
    logic [DATA_W-1:0]       ext_mask;
    logic [DATA_W-1:0]       cap_data;
    logic                    sign_bit;
    logic                    cap_rw;

    logic                    acc;
    logic                    pop;
    logic                    load_h;
    logic                    load_s;
    logic                    h_from_s;

    logic                    valid_q;
    logic                    ready_q;
    logic [DATA_W-1:0]       h_data;
    logic [REG_ADDR_W-1:0]   h_reg;
    logic                    h_rw;
    logic [DATA_W-1:0]       s_data;
    logic [REG_ADDR_W-1:0]   s_reg;
    logic                    s_rw;

    // Capture value: aligned, size-truncated and extended load, or ALU result.
    always_comb begin
        eff_off   = '0;
        keep_mask = '1;
        sign_bit  = 1'b0;
        ext_mask  = '0;
        case (load_size_in)
            2'b00: begin
                eff_off   = byte_off_in;
                keep_mask = MASK_B;
            end
            2'b01: begin
                eff_off   = byte_off_in & HALF_ALIGN;
                keep_mask = MASK_H;
            end
            2'b10: begin
                eff_off   = byte_off_in & WORD_ALIGN;
                keep_mask = MASK_W;
            end
            default: begin
                eff_off   = '0;
                keep_mask = '1;
            end
        endcase
        shifted = read_data_in >> {eff_off, 3'b000};
        case (load_size_in)
            2'b00:   sign_bit = shifted[7];
            2'b01:   sign_bit = shifted[15];
            2'b10:   sign_bit = shifted[31];
            default: sign_bit = 1'b0;
        endcase
        if (load_signed_in && sign_bit) begin
            ext_mask = ~keep_mask;
        end
        cap_data = mem_to_reg_in ? ((shifted & keep_mask) | ext_mask) : alu_result_in;
    end

    // Writes to register 0 are folded in here so the output needs only one AND.
    assign cap_rw = reg_write_in & (write_reg_in != '0);

    assign acc = in_valid & ready_q;
    assign pop = valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (acc) state_nxt = ONE;
                ONE: begin
                    if (acc && !pop) begin
                        state_nxt = FULL;
                    end else if (!acc && pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL:    if (pop) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Register-load strobes; flush suppresses every load.
    always_comb begin
        load_h   = 1'b0;
        load_s   = 1'b0;
        h_from_s = 1'b0;
        if (!flush) begin
            case (state)
                EMPTY: load_h = acc;
                ONE: begin
                    load_h = acc & pop;
                    load_s = acc & ~pop;
                end
                FULL:    h_from_s = pop;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            h_data  <= '0;
            h_reg   <= '0;
            h_rw    <= 1'b0;
            s_data  <= '0;
            s_reg   <= '0;
            s_rw    <= 1'b0;
        end else begin
            valid_q <= (state_nxt != EMPTY);
            ready_q <= (state_nxt != FULL);
            if (load_h) begin
                h_data <= cap_data;
                h_reg  <= write_reg_in;
                h_rw   <= cap_rw;
            end else if (h_from_s) begin
                h_data <= s_data;
                h_reg  <= s_reg;
                h_rw   <= s_rw;
            end
            if (load_s) begin
                s_data <= cap_data;
                s_reg  <= write_reg_in;
                s_rw   <= cap_rw;
            end
            if (flush) begin
                h_rw <= 1'b0;
                s_rw <= 1'b0;
            end
        end
    end

    assign in_ready      = ready_q;
    assign out_valid     = valid_q;
    assign wb_data_out   = h_data;
    assign write_reg_out = h_reg;
    assign reg_write_out = valid_q & h_rw;
    assign fwd_valid     = reg_write_out;
    assign fwd_reg       = h_reg;
    assign fwd_data      = h_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: 32- and 64-bit instances share one
// stimulus stream; expected entries come from a behavioural load model.
module tb_mem_wb_stage;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  reg_idx;
        logic        wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, flush;
    logic [63:0] alu, rdata;
    logic [4:0]  wreg;
    logic        m2r, rw, lsigned;
    logic [1:0]  lsize;
    logic [2:0]  off;

    logic        in_ready32, out_valid32, rwo32, fwdv32;
    logic [31:0] wb32, fwdd32;
    logic [4:0]  wro32, fwdr32;
    logic        in_ready64, out_valid64, rwo64, fwdv64;
    logic [63:0] wb64, fwdd64;
    logic [4:0]  wro64, fwdr64;

    exp_t        exp_in [2];
    exp_t        sb [2][$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
        .alu_result_in(alu[31:0]), .read_data_in(rdata[31:0]), .write_reg_in(wreg),
        .mem_to_reg_in(m2r), .reg_write_in(rw), .load_size_in(lsize),
        .load_signed_in(lsigned), .byte_off_in(off[1:0]), .flush(flush),
        .out_valid(out_valid32), .out_ready(out_ready), .wb_data_out(wb32),
        .write_reg_out(wro32), .reg_write_out(rwo32), .fwd_valid(fwdv32),
        .fwd_reg(fwdr32), .fwd_data(fwdd32)
    );

    mem_wb_stage #(.DATA_W(64)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
        .alu_result_in(alu), .read_data_in(rdata), .write_reg_in(wreg),
        .mem_to_reg_in(m2r), .reg_write_in(rw), .load_size_in(lsize),
        .load_signed_in(lsigned), .byte_off_in(off), .flush(flush),
        .out_valid(out_valid64), .out_ready(out_ready), .wb_data_out(wb64),
        .write_reg_out(wro64), .reg_write_out(rwo64), .fwd_valid(fwdv64),
        .fwd_reg(fwdr64), .fwd_data(fwdd64)
    );

    // Load result as a count of bytes taken from an aligned byte position.
    function automatic logic [63:0] model(int unsigned dw, logic [63:0] a, logic [63:0] d,
                                          logic m, logic [1:0] sz, logic sg, logic [2:0] o);
        int unsigned nbytes, boff;
        logic [63:0] v, keep, dmask;
        dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (!m) return a & dmask;
        case (sz)
            2'd0:    nbytes = 1;
            2'd1:    nbytes = 2;
            2'd2:    nbytes = 4;
            default: nbytes = dw / 8;
        endcase
        boff = int'(o) % (dw / 8);
        boff = boff - (boff % nbytes);
        v    = (d & dmask) >> (8 * boff);
        keep = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
        v    = v & keep;
        if (sg && v[8 * nbytes - 1]) v = v | ~keep;
        return v & dmask;
    endfunction

    task automatic chk(string name, int s, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (DATA_W=%0d): got 0x%0h, expected 0x%0h",
                      name, (s != 0) ? 64 : 32, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(logic iv, logic [63:0] a, logic [63:0] d, logic [4:0] r,
                          logic m, logic w, logic [1:0] sz, logic sg, logic [2:0] o);
        in_valid = iv; alu = a; rdata = d; wreg = r;
        m2r = m; rw = w; lsize = sz; lsigned = sg; off = o;
        exp_in[0].data    = model(32, a, d, m, sz, sg, o);
        exp_in[1].data    = model(64, a, d, m, sz, sg, o);
        exp_in[0].reg_idx = r;
        exp_in[1].reg_idx = r;
        exp_in[0].wr      = w && (r != 5'd0);
        exp_in[1].wr      = w && (r != 5'd0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Hold the current input until both instances take it, bounded.
    task automatic wait_accept();
        logic ok;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok = in_ready32 && in_ready64;
            tick();
            if (ok) return;
        end
        n_checks++;
        $display("FAIL accept_timeout: in_ready stayed low for 20 cycles, expected acceptance");
    endtask

    task automatic reset_checks(int s, logic ir, logic ov, logic [63:0] wb, logic [4:0] wr,
                                logic rwo, logic fv, logic [4:0] fr, logic [63:0] fd);
        chk("reset in_ready", s, 64'(ir), 64'd1);
        chk("reset out_valid", s, 64'(ov), 64'd0);
        chk("reset wb_data_out", s, wb, 64'd0);
        chk("reset write_reg_out", s, 64'(wr), 64'd0);
        chk("reset reg_write_out", s, 64'(rwo), 64'd0);
        chk("reset fwd_valid", s, 64'(fv), 64'd0);
        chk("reset fwd_reg", s, 64'(fr), 64'd0);
        chk("reset fwd_data", s, fd, 64'd0);
    endtask

    task automatic side_step(int s, logic ir, logic ov, logic [63:0] wb, logic [4:0] wr,
                             logic rwo, logic fv, logic [4:0] fr, logic [63:0] fd);
        exp_t e;
        chk("in_ready", s, 64'(ir), 64'(sb[s].size() < 2));
        chk("out_valid", s, 64'(ov), 64'(sb[s].size() != 0));
        if (ov && sb[s].size() != 0) begin
            e = sb[s][0];
            chk("wb_data_out", s, wb, e.data);
            chk("write_reg_out", s, 64'(wr), 64'(e.reg_idx));
            chk("reg_write_out", s, 64'(rwo), 64'(e.wr));
            chk("fwd_valid", s, 64'(fv), 64'(e.wr));
            chk("fwd_reg", s, 64'(fr), 64'(e.reg_idx));
            chk("fwd_data", s, fd, e.data);
            if (out_ready) void'(sb[s].pop_front());
        end else if (!ov) begin
            chk("idle reg_write_out", s, 64'(rwo), 64'd0);
            chk("idle fwd_valid", s, 64'(fv), 64'd0);
        end
        if (flush) sb[s].delete();
        else if (in_valid && ir) sb[s].push_back(exp_in[s]);
    endtask

    // Monitor: compares head against scoreboard and records accepted entries.
    always @(negedge clk) begin
        if (reset) begin
            sb[0].delete();
            sb[1].delete();
        end else begin
            side_step(0, in_ready32, out_valid32, 64'(wb32), wro32, rwo32, fwdv32, fwdr32, 64'(fwdd32));
            side_step(1, in_ready64, out_valid64, wb64, wro64, rwo64, fwdv64, fwdr64, fwdd64);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0, 3'd0);
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        reset_checks(0, in_ready32, out_valid32, 64'(wb32), wro32, rwo32, fwdv32, fwdr32, 64'(fwdd32));
        reset_checks(1, in_ready64, out_valid64, wb64, wro64, rwo64, fwdv64, fwdr64, fwdd64);
        tick();

        // ALU pass-through with forwarding
        out_ready = 1'b1;
        set_in(1'b1, 64'h1234, 64'h0, 5'd9, 1'b0, 1'b1, 2'b11, 1'b0, 3'd0);
        exp_in[0].data = 64'h1234;
        wait_accept();
        idle(); repeat (2) tick();

        // Sub-word loads from 0x80FF_7F01
        set_in(1'b1, 64'h5, 64'h80FF_7F01, 5'd1, 1'b1, 1'b1, 2'b00, 1'b1, 3'd3);
        exp_in[0].data = 64'hFFFF_FF80; wait_accept();
        set_in(1'b1, 64'h5, 64'h80FF_7F01, 5'd2, 1'b1, 1'b1, 2'b00, 1'b0, 3'd3);
        exp_in[0].data = 64'h0000_0080; wait_accept();
        set_in(1'b1, 64'h5, 64'h80FF_7F01, 5'd3, 1'b1, 1'b1, 2'b01, 1'b1, 3'd2);
        exp_in[0].data = 64'hFFFF_80FF; wait_accept();
        set_in(1'b1, 64'h5, 64'h80FF_7F01, 5'd4, 1'b1, 1'b1, 2'b01, 1'b0, 3'd1);
        exp_in[0].data = 64'h0000_7F01; wait_accept();
        set_in(1'b1, 64'h5, 64'h80FF_7F01, 5'd5, 1'b1, 1'b1, 2'b10, 1'b0, 3'd0);
        exp_in[0].data = 64'h80FF_7F01; wait_accept();

        // 64-bit full-width and upper-word loads
        set_in(1'b1, 64'h5, 64'h8000_0000_0000_0001, 5'd6, 1'b1, 1'b1, 2'b11, 1'b1, 3'd5);
        exp_in[1].data = 64'h8000_0000_0000_0001; wait_accept();
        set_in(1'b1, 64'h5, 64'h8000_0000_0000_0001, 5'd7, 1'b1, 1'b1, 2'b10, 1'b1, 3'd4);
        exp_in[1].data = 64'hFFFF_FFFF_8000_0000; wait_accept();

        // Write to register 0 stays invisible to write-back enables
        set_in(1'b1, 64'hDEAD, 64'h0, 5'd0, 1'b0, 1'b1, 2'b11, 1'b0, 3'd0);
        wait_accept();
        idle(); repeat (3) tick();

        // Back-pressure: A and B fill the buffer, C is held off
        out_ready = 1'b0;
        set_in(1'b1, 64'hA, 64'h0, 5'd10, 1'b0, 1'b1, 2'b11, 1'b0, 3'd0); wait_accept();
        set_in(1'b1, 64'hB, 64'h0, 5'd11, 1'b0, 1'b1, 2'b11, 1'b0, 3'd0); wait_accept();
        set_in(1'b1, 64'hC, 64'h0, 5'd12, 1'b0, 1'b1, 2'b11, 1'b0, 3'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("backpressure in_ready", 0, 64'(in_ready32), 64'd0);
        chk("backpressure in_ready", 1, 64'(in_ready64), 64'd0);
        tick();
        out_ready = 1'b1;
        wait_accept();
        idle(); repeat (4) tick();

        // Flush while full with a pending input
        out_ready = 1'b0;
        set_in(1'b1, 64'h1, 64'h0, 5'd13, 1'b0, 1'b1, 2'b11, 1'b0, 3'd0); wait_accept();
        set_in(1'b1, 64'h2, 64'h0, 5'd14, 1'b0, 1'b1, 2'b11, 1'b0, 3'd0); wait_accept();
        set_in(1'b1, 64'h3, 64'h0, 5'd15, 1'b0, 1'b1, 2'b11, 1'b0, 3'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0; idle();
        @(negedge clk);
        chk("flush out_valid", 0, 64'(out_valid32), 64'd0);
        chk("flush in_ready", 0, 64'(in_ready32), 64'd1);
        chk("flush reg_write_out", 0, 64'(rwo32), 64'd0);
        chk("flush out_valid", 1, 64'(out_valid64), 64'd0);
        chk("flush in_ready", 1, 64'(in_ready64), 64'd1);
        chk("flush reg_write_out", 1, 64'(rwo64), 64'd0);
        tick();

        // Random traffic with flushes, a mid-run reset and a streaming window
        for (int c = 0; c < 1500; c++) begin
            logic       m;
            logic [1:0] sz;
            m  = 1'($urandom_range(0, 1));
            sz = m ? 2'($urandom_range(0, 3)) : 2'b11;
            set_in($urandom_range(0, 9) < 7, {$urandom, $urandom}, {$urandom, $urandom},
                   5'($urandom_range(0, 31)), m, 1'($urandom_range(0, 1)), sz,
                   1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            out_ready = (c >= 1000 && c < 1200) ? 1'b1 : ($urandom_range(0, 9) < 6);
            flush     = (c < 1000 || c >= 1200) && ($urandom_range(0, 29) == 0);
            reset     = (c == 700 || c == 701);
            tick();
        end

        // Drain whatever is still held
        flush = 1'b0; reset = 1'b0; idle(); out_ready = 1'b1;
        for (int i = 0; i < 10 && (sb[0].size() != 0 || sb[1].size() != 0); i++) tick();
        n_checks++;
        if (sb[0].size() == 0 && sb[1].size() == 0) n_pass++;
        else $display("FAIL drain: %0d/%0d entries still expected, expected 0",
                      sb[0].size(), sb[1].size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline stage replacing the fixed 32-bit MEM/WB register. It sits between data memory and the register-file write port. It adds a valid/ready handshake with a two-entry skid buffer, so write-back back-pressure never creates a combinational ready path into MEM. It also adds a synchronous flush, sub-word load alignment with sign/zero extension, and a forwarding tap for the EX-stage bypass network.

## Interface
Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64
- REG_ADDR_W, 5, register index width
- OFF_W, $clog2(DATA_W/8), byte-offset width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high
- in_valid  in  1  MEM presents an instruction
- in_ready  out  1  stage accepts; registered, equals !(count==2)
- alu_result_in  in  DATA_W  ALU result / address
- read_data_in  in  DATA_W  raw memory word
- write_reg_in  in  REG_ADDR_W  destination register
- mem_to_reg_in  in  1  1 selects load data, 0 selects ALU result
- reg_write_in  in  1  instruction writes a register
- load_size_in  in  2  00 byte, 01 half, 10 word, 11 full DATA_W
- load_signed_in  in  1  sign-extend sub-width loads
- byte_off_in  in  OFF_W  byte offset within read_data_in
- flush  in  1  discard all held and incoming entries
- out_valid  out  1  head entry valid
- out_ready  in  1  write-back consumes head
- wb_data_out  out  DATA_W  final write-back value of head
- write_reg_out  out  REG_ADDR_W  head destination
- reg_write_out  out  1  out_valid & head.reg_write & (head.write_reg != 0)
- fwd_valid  out  1  equals reg_write_out
- fwd_reg  out  REG_ADDR_W  equals write_reg_out
- fwd_data  out  DATA_W  equals wb_data_out

## Operation
- Entry = {wb_data, write_reg, reg_write}. wb_data is computed combinationally from the inputs at capture and is the only data stored; the raw ALU result and raw memory word are not retained.
- wb_data at capture:
  - mem_to_reg=0: alu_result_in.
  - mem_to_reg=1: shift read_data_in right by 8*byte_off_in.
  - Then keep 8 (size 00), 16 (01), 32 (10) or DATA_W (11) low bits.
  - Upper bits: sign bit replicated if load_signed_in, else zeros.
  - Half: byte_off_in[0] is ignored (treated as 0).
  - Word with DATA_W=64: byte_off_in[1:0] are ignored.
  - Size 11: byte_off_in is ignored; size 11 at DATA_W=32 equals size 10.
  - Misalignment raises no error (exceptions are handled upstream).
- Storage: head register H and skid register S; count ∈ {0,1,2}. States EMPTY (0), ONE (1), FULL (2).
- Let acc = in_valid & in_ready and pop = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY: acc → H←in, ONE.
  - ONE: acc&!pop → S←in, FULL. acc&pop → H←in, stay ONE. !acc&pop → EMPTY. Otherwise hold.
  - FULL: pop → H←S, ONE. No acc is possible because in_ready=0.
- Entries leave in strict FIFO order. No entry is duplicated or dropped absent flush.
- flush=1: next state EMPTY and reg_write bits cleared. The same-cycle acc is discarded, and in_ready rises next cycle. A same-cycle pop is still a valid handoff to write-back.
- reset=1: identical to flush, and takes priority over all other inputs.

## Timing
- Reset values: out_valid=0, in_ready=1, reg_write_out=0, fwd_valid=0, wb_data_out=0, write_reg_out=0, fwd_reg=0, fwd_data=0; count=0; H and S cleared.
- Latency: accept at edge N → out_valid=1 with the entry's data after edge N, when previously empty.
- Throughput: one instruction per cycle with out_ready held high. count never exceeds 1 in that mode.
- in_ready depends only on registered count, never on out_ready in the same cycle.
- All outputs are driven from registers plus at most a single AND gate (reg_write_out).
- While out_valid=1 and out_ready=0, all head outputs are held stable.

## Test plan
- Reset, then write_reg=9, ALU 0x0000_1234, mem_to_reg=0, reg_write=1 with out_ready=1 → one cycle later out_valid=1, wb_data_out=0x1234, reg_write_out=1, fwd_reg=9.
- Loads, read_data=0x80FF_7F01, DATA_W=32:
  - lb off 3 → 0xFFFF_FF80.
  - lbu off 3 → 0x0000_0080.
  - lh off 2 → 0xFFFF_80FF.
  - lhu off 1 → 0x0000_7F01 (bit 0 ignored).
  - lw → 0x80FF_7F01.
- Back-pressure: out_ready=0, send A,B → in_ready=0 after B, C held off. Release out_ready → A, then B, then C on consecutive cycles with no loss.
- Flush with count=2 and in_valid=1 → next cycle out_valid=0, in_ready=1, reg_write_out=0. The flushed incoming entry never appears.
- Write to $0 (write_reg=0, reg_write=1) → out_valid=1, reg_write_out=0, fwd_valid=0.
- DATA_W=64, ld size 11, read_data=0x8000_0000_0000_0001 → wb_data_out unchanged. lw signed off 4 → 0xFFFF_FFFF_8000_0000.
